// File: rtl/secuenciador_banco_if.sv
// Command/response channel between a requester and the register-bank sequencer.
// The requester drives the command fields; the sequencer drives ready and the response.
interface secuenciador_banco_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addrA;
  logic [ADDR_W-1:0] cmd_addrB;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_datA;
  logic [DATA_W-1:0] rsp_datB;

  modport master (
    output cmd_valid, cmd_op, cmd_addrA, cmd_addrB, cmd_data,
    input  cmd_ready, rsp_valid, rsp_datA, rsp_datB
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addrA, cmd_addrB, cmd_data,
    output cmd_ready, rsp_valid, rsp_datA, rsp_datB
  );
endinterface

// File: rtl/secuenciador_banco.sv
// Register-bank command sequencer: WRITE/READ respond at cycle 2, FILL at 2^ADDR_W+1, CLEAR at 3.
// One command in flight; cmd_ready only in IDLE, requester holds cmd_valid until accepted.
module secuenciador_banco #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  secuenciador_banco_if.slave cmdIf,
  output logic [ADDR_W-1:0]   addrRa,
  output logic [ADDR_W-1:0]   addrRb,
  input  logic [DATA_W-1:0]   datOutRa,
  input  logic [DATA_W-1:0]   datOutRb,
  output logic [ADDR_W-1:0]   addrW,
  output logic [DATA_W-1:0]   datW,
  output logic                RegWrite,
  output logic                bankRst
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    FILL  = 3'd3,
    CLEAR = 3'd4,
    RESP  = 3'd5
  } state_t;

  localparam logic [1:0]        OP_WRITE  = 2'b00;
  localparam logic [1:0]        OP_READ   = 2'b01;
  localparam logic [1:0]        OP_FILL   = 2'b10;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, stateNxt;
  logic              clrPhase, clrPhaseNxt;
  logic              readyNxt, rspValidNxt;
  logic [DATA_W-1:0] rspDatANxt, rspDatBNxt;
  logic [ADDR_W-1:0] addrRaNxt, addrRbNxt, addrWNxt;
  logic [DATA_W-1:0] datWNxt;
  logic              regWriteNxt, bankRstNxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next values of every output are computed here and registered below,
  // so each output changes only on a clock edge (or asynchronously on rst).
  always_comb begin
    stateNxt    = state;
    clrPhaseNxt = clrPhase;
    readyNxt    = 1'b0;
    rspValidNxt = 1'b0;
    rspDatANxt  = cmdIf.rsp_datA;
    rspDatBNxt  = cmdIf.rsp_datB;
    addrRaNxt   = addrRa;
    addrRbNxt   = addrRb;
    addrWNxt    = addrW;
    datWNxt     = datW;
    regWriteNxt = 1'b0;
    bankRstNxt  = 1'b0;

    case (state)
      IDLE: begin
        readyNxt = 1'b1;
        if (cmdIf.cmd_valid && cmdIf.cmd_ready) begin
          readyNxt = 1'b0;
          case (cmdIf.cmd_op)
            OP_WRITE: begin
              stateNxt    = WRITE;
              regWriteNxt = 1'b1;
              addrWNxt    = cmdIf.cmd_addrA;
              datWNxt     = cmdIf.cmd_data;
            end
            OP_READ: begin
              stateNxt  = READ;
              addrRaNxt = cmdIf.cmd_addrA;
              addrRbNxt = cmdIf.cmd_addrB;
            end
            OP_FILL: begin
              stateNxt    = FILL;
              regWriteNxt = 1'b1;
              addrWNxt    = '0;
              datWNxt     = cmdIf.cmd_data;
            end
            default: begin
              stateNxt    = CLEAR;
              regWriteNxt = 1'b1;
              bankRstNxt  = 1'b1;
              clrPhaseNxt = 1'b0;
            end
          endcase
        end
      end

      WRITE: begin
        stateNxt    = RESP;
        rspValidNxt = 1'b1;
      end

      READ: begin
        rspDatANxt  = datOutRa;
        rspDatBNxt  = datOutRb;
        stateNxt    = RESP;
        rspValidNxt = 1'b1;
      end

      // addrW doubles as the fill counter and wraps back to 0 after the last address
      FILL: begin
        addrWNxt = addrW + 1'b1;
        if (addrW == LAST_ADDR) begin
          stateNxt    = RESP;
          rspValidNxt = 1'b1;
        end else begin
          regWriteNxt = 1'b1;
        end
      end

      CLEAR: begin
        if (!clrPhase) begin
          regWriteNxt = 1'b1;
          bankRstNxt  = 1'b1;
          clrPhaseNxt = 1'b1;
        end else begin
          stateNxt    = RESP;
          rspValidNxt = 1'b1;
        end
      end

      RESP: begin
        stateNxt = IDLE;
        readyNxt = 1'b1;
      end

      default: begin
        stateNxt = IDLE;
        readyNxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clrPhase        <= 1'b0;
      cmdIf.cmd_ready <= 1'b1;
      cmdIf.rsp_valid <= 1'b0;
      cmdIf.rsp_datA  <= '0;
      cmdIf.rsp_datB  <= '0;
      addrRa          <= '0;
      addrRb          <= '0;
      addrW           <= '0;
      datW            <= '0;
      RegWrite        <= 1'b0;
      bankRst         <= 1'b0;
    end else begin
      clrPhase        <= clrPhaseNxt;
      cmdIf.cmd_ready <= readyNxt;
      cmdIf.rsp_valid <= rspValidNxt;
      cmdIf.rsp_datA  <= rspDatANxt;
      cmdIf.rsp_datB  <= rspDatBNxt;
      addrRa          <= addrRaNxt;
      addrRb          <= addrRbNxt;
      addrW           <= addrWNxt;
      datW            <= datWNxt;
      RegWrite        <= regWriteNxt;
      bankRst         <= bankRstNxt;
    end
  end

endmodule

// File: tb/tb_secuenciador_banco.sv
// Directed bench for secuenciador_banco driving an 8x4 register bank model.
module tb_secuenciador_banco;

  logic       clk;
  logic       rst;
  logic [2:0] addrRa, addrRb, addrW;
  logic [3:0] datOutRa, datOutRb, datW;
  logic       RegWrite, bankRst;
  logic [3:0] mem [8];

  int nCompared   = 0;
  int nMismatched = 0;
  int wrCnt, brCnt, lastLat;
  bit seqBad;

  secuenciador_banco_if #(.ADDR_W(3), .DATA_W(4)) cmdIf ();

  secuenciador_banco #(.ADDR_W(3), .DATA_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmdIf    (cmdIf),
    .addrRa   (addrRa),
    .addrRb   (addrRb),
    .datOutRa (datOutRa),
    .datOutRb (datOutRb),
    .addrW    (addrW),
    .datW     (datW),
    .RegWrite (RegWrite),
    .bankRst  (bankRst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: combinational reads, synchronous write, clear while RegWrite && bankRst
  assign datOutRa = mem[addrRa];
  assign datOutRb = mem[addrRb];
  always @(posedge clk) begin
    if (RegWrite) begin
      if (bankRst) for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
      else         mem[addrW] <= datW;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendCmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [3:0] d, input int expLat, input string tag);
    bit got;
    wrCnt   = 0;
    brCnt   = 0;
    seqBad  = 0;
    lastLat = 0;
    @(negedge clk);
    cmdIf.cmd_op    = op;
    cmdIf.cmd_addrA = a;
    cmdIf.cmd_addrB = b;
    cmdIf.cmd_data  = d;
    cmdIf.cmd_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (cmdIf.cmd_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      checkVal($sformatf("%s_accept", tag), 0, 1);
      cmdIf.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the fields so a design that fails to latch them is caught
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = ~op;
    cmdIf.cmd_addrA = ~a;
    cmdIf.cmd_addrB = ~b;
    cmdIf.cmd_data  = ~d;
    for (int k = 1; k <= 20 && lastLat == 0; k++) begin
      @(negedge clk);
      if (RegWrite) begin
        if (addrW != wrCnt[2:0]) seqBad = 1;
        wrCnt++;
      end
      if (bankRst) brCnt++;
      if (cmdIf.rsp_valid) lastLat = k;
    end
    checkVal($sformatf("%s_lat", tag), lastLat, expLat);
    @(negedge clk);
    checkVal($sformatf("%s_idle", tag), {cmdIf.rsp_valid, cmdIf.cmd_ready}, 2'b01);
  endtask

  task automatic doWrite(input logic [2:0] a, input logic [3:0] d, input string tag);
    sendCmd(2'b00, a, 3'd0, d, 2, tag);
    checkVal($sformatf("%s_wr", tag), wrCnt, 1);
  endtask

  task automatic doRead(input logic [2:0] a, input logic [2:0] b,
                        input logic [3:0] expA, input logic [3:0] expB, input string tag);
    sendCmd(2'b01, a, b, 4'h0, 2, tag);
    checkVal($sformatf("%s_wr", tag), wrCnt, 0);
    checkVal($sformatf("%s_datAB", tag), {cmdIf.rsp_datA, cmdIf.rsp_datB}, {expA, expB});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sawRsp;
    for (int i = 0; i < 8; i++) mem[i] = 4'h0;
    cmdIf.cmd_valid = 1'b0;
    cmdIf.cmd_op    = 2'b00;
    cmdIf.cmd_addrA = 3'd0;
    cmdIf.cmd_addrB = 3'd0;
    cmdIf.cmd_data  = 4'h0;
    rst = 1'b1;

    @(negedge clk);
    checkVal("rst_rdy", cmdIf.cmd_ready, 1);
    checkVal("rst_rsp", {cmdIf.rsp_valid, cmdIf.rsp_datA, cmdIf.rsp_datB}, 0);
    checkVal("rst_bank", {addrRa, addrRb, addrW, datW, RegWrite, bankRst}, 0);
    @(negedge clk);
    rst = 1'b0;

    doWrite(3'd5, 4'hA, "w5");
    doRead(3'd5, 3'd0, 4'hA, 4'h0, "r5_0");

    for (int a = 0; a < 8; a++) doWrite(3'(a), 4'(15 - a), $sformatf("pw%0d", a));
    for (int a = 0; a < 4; a++)
      doRead(3'(a), 3'(7 - a), 4'(15 - a), 4'(8 + a), $sformatf("pr%0d", a));

    sendCmd(2'b10, 3'd0, 3'd0, 4'h3, 9, "fill3");
    checkVal("fill3_wr", wrCnt, 8);
    checkVal("fill3_seq", seqBad, 0);
    for (int a = 0; a < 4; a++)
      doRead(3'(a), 3'(7 - a), 4'h3, 4'h3, $sformatf("fr%0d", a));

    sendCmd(2'b11, 3'd0, 3'd0, 4'h0, 3, "clr");
    checkVal("clr_brst", brCnt, 2);
    checkVal("clr_wr", wrCnt, 2);
    for (int a = 0; a < 4; a++)
      doRead(3'(a), 3'(7 - a), 4'h0, 4'h0, $sformatf("cr%0d", a));

    doWrite(3'd5, 4'hC, "w5c");
    doRead(3'd5, 3'd5, 4'hC, 4'hC, "r5c");

    // Abort FILL 0x6 right after the edge that writes address 3
    @(negedge clk);
    checkVal("ab_rdy", cmdIf.cmd_ready, 1);
    cmdIf.cmd_op    = 2'b10;
    cmdIf.cmd_data  = 4'h6;
    cmdIf.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmdIf.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkVal("ab_wr_before", RegWrite, 1);
    rst = 1'b1;
    #1;
    checkVal("ab_wr_drop", {RegWrite, bankRst}, 0);
    checkVal("ab_rsp_dat", {cmdIf.rsp_datA, cmdIf.rsp_datB}, 0);
    checkVal("ab_rdy_rst", cmdIf.cmd_ready, 1);
    sawRsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (cmdIf.rsp_valid || RegWrite) sawRsp = 1;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cmdIf.rsp_valid || RegWrite) sawRsp = 1;
    end
    checkVal("ab_norsp", sawRsp, 0);
    doRead(3'd0, 3'd4, 4'h6, 4'h0, "ar0_4");
    doRead(3'd1, 3'd5, 4'h6, 4'hC, "ar1_5");
    doRead(3'd2, 3'd6, 4'h6, 4'h0, "ar2_6");
    doRead(3'd3, 3'd7, 4'h6, 4'h0, "ar3_7");

    doWrite(3'd7, 4'h9, "w7");
    doRead(3'd7, 3'd0, 4'h9, 4'h6, "r7_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
